// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
package mem_pkg;

    localparam int unsigned ADDR_LIMIT_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
    } state_e;

    // Byte stores replicate the low byte into every lane so the memory can
    // pick whichever lane the address selects.
    function automatic logic [31:0] format_wdata(input logic is_byte, input logic [31:0] wdata);
        return is_byte ? {4{wdata[7:0]}} : wdata;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake bundle.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load data formatting: lane selection for byte loads plus sign/zero extension.
module load_extend (
    input  logic [31:0] rd_i,
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [7:0] byte_sel;

    // The memory returns the whole word; the addressed byte sits in lane addr[1:0].
    always_comb begin
        byte_sel = rd_i[7:0];
        case (lane_i)
            2'd0: byte_sel = rd_i[7:0];
            2'd1: byte_sel = rd_i[15:8];
            2'd2: byte_sel = rd_i[23:16];
            2'd3: byte_sel = rd_i[31:24];
            default: byte_sel = rd_i[7:0];
        endcase
        if (byte_i)
            data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        else
            data_o = rd_i;
    end
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between a core and a byte-addressed data memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus,
    output logic               mem_we,
    output logic               mem_be,
    output logic [31:0]        mem_a,
    output logic [31:0]        mem_wd,
    input  logic [31:0]        mem_rd
);
    state_e      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_we_q;
    logic        mem_be_q;
    logic [31:0] mem_a_q;
    logic [31:0] mem_wd_q;
    logic        byte_q;
    logic        signed_q;
    logic [1:0]  lane_q;

    logic        fault_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data_d;

    // Misaligned word access or out-of-range address faults without touching memory.
    always_comb begin
        fault_d = (!bus.req_byte && (bus.req_addr[1:0] != 2'b00)) || (bus.req_addr >= ADDR_LIMIT);
        wdata_d = format_wdata(bus.req_byte, bus.req_wdata);
    end

    load_extend u_load_extend (
        .rd_i     (mem_rd),
        .lane_i   (lane_q),
        .byte_i   (byte_q),
        .signed_i (signed_q),
        .data_o   (load_data_d)
    );

    // Control FSM with all outputs registered; mem_* are only non-zero in WRITE/READ/CAPTURE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            byte_q       <= 1'b0;
            signed_q     <= 1'b0;
            lane_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        byte_q      <= bus.req_byte;
                        signed_q    <= bus.req_signed;
                        lane_q      <= bus.req_addr[1:0];
                        if (fault_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (bus.req_write) begin
                            state_q  <= WRITE;
                            mem_we_q <= 1'b1;
                            mem_be_q <= bus.req_byte;
                            mem_a_q  <= bus.req_addr;
                            mem_wd_q <= wdata_d;
                        end else begin
                            state_q  <= READ;
                            mem_be_q <= bus.req_byte;
                            mem_a_q  <= bus.req_addr;
                            mem_wd_q <= '0;
                        end
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    mem_we_q     <= 1'b0;
                    mem_be_q     <= 1'b0;
                    mem_a_q      <= '0;
                    mem_wd_q     <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                READ: begin
                    // Address has been on the bus one cycle; data is valid by the end of CAPTURE.
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    state_q      <= RESP;
                    mem_be_q     <= 1'b0;
                    mem_a_q      <= '0;
                    mem_wd_q     <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_data_d;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign mem_we         = mem_we_q;
    assign mem_be         = mem_be_q;
    assign mem_a          = mem_a_q;
    assign mem_wd         = mem_wd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-organised memory model.
module tb_mem_access_unit;
    logic        clk;
    logic        reset;
    logic        mem_we, mem_be;
    logic [31:0] mem_a, mem_wd, mem_rd;
    int          checks;
    int          errors;
    int          we_cnt;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    mem_access_unit_if bus();

    mem_access_unit #(.ADDR_LIMIT(256)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .mem_we (mem_we),
        .mem_be (mem_be),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preload port from the bench, byte/word writes from the DUT.
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (mem_we) begin
            if (mem_be)
                mem[mem_a[7:2]][8*mem_a[1:0] +: 8] <= mem_wd[8*mem_a[1:0] +: 8];
            else
                mem[mem_a[7:2]] <= mem_wd;
        end
    end

    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    assign mem_rd = mem[mem_a[7:2]];

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Drives one request; returns 1 time unit after the accepting edge.
    task automatic send(input logic w, input logic b, input logic s,
                        input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_before_send got %b want 1", bus.req_ready);
        end
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_byte = b;
        bus.req_signed = s; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic release_resp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL back_to_idle got ready=%b valid=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
            bus.resp_rdata !== 32'h0 || mem_we !== 1'b0 || mem_be !== 1'b0 ||
            mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b e=%b rd=%h we=%b be=%b a=%h wd=%h want 1 0 0 0 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, mem_we, mem_be, mem_a, mem_wd);
        end
    endtask

    task automatic test_word_store();
        int we0;
        we0 = we_cnt;
        send(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'h10 || mem_be !== 1'b0 || mem_wd !== 32'hDEADBEEF || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wstore_cycle1 got we=%b a=%h be=%b wd=%h v=%b want 1 10 0 deadbeef 0",
                     mem_we, mem_a, mem_be, mem_wd, bus.resp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0 ||
            mem_we !== 1'b0 || mem_a !== 32'h0 || (we_cnt - we0) !== 1) begin
            errors++;
            $display("FAIL wstore_cycle2 got v=%b e=%b rd=%h we=%b a=%h pulses=%0d want 1 0 0 0 0 1",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, mem_we, mem_a, we_cnt - we0);
        end
        release_resp();
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wstore_mem got %h want deadbeef", mem[4]);
        end
    endtask

    task automatic test_byte_load(input logic s, input logic [31:0] exp);
        int we0;
        preload(6'd4, 32'h80FF0000);
        we0 = we_cnt;
        send(1'b0, 1'b1, s, 32'h13, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_a !== 32'h13 || mem_be !== 1'b1 || mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bload_read got a=%h be=%b we=%b v=%b want 13 1 0 0", mem_a, mem_be, mem_we, bus.resp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL bload_cycle2_valid got %b want 0", bus.resp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp || bus.resp_err !== 1'b0 || (we_cnt - we0) !== 0) begin
            errors++;
            $display("FAIL bload_s%0d got v=%b rd=%h e=%b pulses=%0d want 1 %h 0 0",
                     s, bus.resp_valid, bus.resp_rdata, bus.resp_err, we_cnt - we0, exp);
        end
        release_resp();
    endtask

    task automatic test_byte_store_word_load();
        preload(6'd8, 32'h0);
        send(1'b1, 1'b1, 1'b1, 32'h21, 32'h123456A5);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_be !== 1'b1 || mem_wd !== 32'hA5A5A5A5 || mem_a !== 32'h21) begin
            errors++;
            $display("FAIL bstore got we=%b be=%b wd=%h a=%h want 1 1 a5a5a5a5 21", mem_we, mem_be, mem_wd, mem_a);
        end
        release_resp();
        // Word load ignores req_signed; top bit of a set byte must not extend.
        send(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0000A500) begin
            errors++; $display("FAIL wload got v=%b rd=%h want 1 0000a500", bus.resp_valid, bus.resp_rdata);
        end
        release_resp();
    endtask

    task automatic test_fault(input logic w, input logic b, input logic [31:0] addr, input logic exp_err);
        int we0;
        we0 = we_cnt;
        send(w, b, 1'b0, addr, 32'hFFFFFFFF);
        @(negedge clk);
        checks++;
        if (exp_err) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL fault_%h got v=%b e=%b rd=%h we=%b want 1 1 0 0", addr, bus.resp_valid, bus.resp_err, bus.resp_rdata, mem_we);
            end
        end else begin
            if (bus.resp_valid !== 1'b0) begin
                errors++; $display("FAIL nofault_%h got v=%b want 0", addr, bus.resp_valid);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== exp_err || (exp_err && (we_cnt - we0) !== 0)) begin
            errors++;
            $display("FAIL fault_end_%h got v=%b e=%b pulses=%0d want 1 %b", addr, bus.resp_valid, bus.resp_err, we_cnt - we0, exp_err);
        end
        release_resp();
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        preload(6'd2, 32'h01234567);
        send(1'b0, 1'b0, 1'b0, 32'h08, 32'h0);
        repeat (3) @(negedge clk);
        first = bus.resp_rdata;
        checks++;
        if (first !== 32'h01234567) begin
            errors++; $display("FAIL bp_data got %h want 01234567", first);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h01234567 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got v=%b rd=%h rdy=%b want 1 01234567 0", i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
            end
        end
        release_resp();
    endtask

    task automatic test_reset_mid();
        send(1'b1, 1'b0, 1'b0, 32'h14, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++; $display("FAIL rmid_write got we=%b want 1", mem_we);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (mem_we !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after got we=%b v=%b rdy=%b want 0 0 1", mem_we, bus.resp_valid, bus.req_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rmid_no_resp got v=%b we=%b want 0 0", bus.resp_valid, mem_we);
        end
    endtask

    initial begin
        checks = 0; errors = 0; we_cnt = 0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_word_store();
        test_byte_load(1'b1, 32'hFFFFFF80);
        test_byte_load(1'b0, 32'h00000080);
        test_byte_store_word_load();
        test_fault(1'b0, 1'b0, 32'h06, 1'b1);
        test_fault(1'b0, 1'b0, 32'h100, 1'b1);
        test_fault(1'b1, 1'b0, 32'h100, 1'b1);
        test_fault(1'b1, 1'b1, 32'h101, 1'b1);
        test_fault(1'b0, 1'b1, 32'hFF, 1'b0);
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
